// File: rtl/grant_pkg.sv
// Shared types and defaults for the grant scheduler: FSM encoding, hold limit, round-robin pick.
// Latency: n/a (declarations and a purely combinational helper function).
// Backpressure: n/a.
package grant_pkg;

    localparam int DEFAULT_MAX_HOLD = 16;
    localparam int NUM_REQ          = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] id;
    } pick_t;

    // Round-robin search starting at ptr. The loop walks offsets from the far
    // end toward ptr so the closest requester (smallest offset) is written last
    // and therefore wins.
    function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        pick_t      p;
        logic [2:0] idx;
        p.found = 1'b0;
        p.id    = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.id    = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/grant_decoder.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when en is low.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: sel [2:0] index to decode, en gate, onehot [7:0] decoded vector.
module grant_decoder (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'd0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/grant_scheduler.sv
// 8-way round-robin grant scheduler with hold timeout and a one-cycle hand-over gap.
// Latency: grant registered one clock after req is sampled; release/timeout take effect one edge later.
// Backpressure: none; requesters hold req until granted, enable low revokes/blocks grants.
// Ports: clk, reset (async, active-high), enable, req[7:0] in;
//        gnt[7:0] one-hot, gnt_valid, gnt_id[2:0], expired (timeout pulse) out.
module grant_scheduler
    import grant_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_id,
    output logic       expired
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       expired_q, expired_d;

    pick_t      pick;
    logic       others_pending;
    logic       hold_done;

    assign pick           = rr_pick(req, ptr_q);
    // gnt is decoded from registered state, so masking with it removes only the current holder.
    assign others_pending = |(req & ~gnt);
    assign hold_done      = (hcnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hcnt_d      = hcnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        expired_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                hcnt_d = 8'd0;
                if (enable && pick.found) begin
                    state_d     = ST_GRANT;
                    gnt_id_d    = pick.id;
                    gnt_valid_d = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                end
            end

            ST_GRANT: begin
                // Voluntary release and enable-drop are checked first so that a
                // release coinciding with the timeout never reports expired.
                if (!enable || !req[gnt_id_q]) begin
                    state_d     = ST_RELEASE;
                    ptr_d       = gnt_id_q + 3'd1;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    hcnt_d      = 8'd0;
                end else if (hold_done && others_pending) begin
                    state_d     = ST_RELEASE;
                    ptr_d       = gnt_id_q + 3'd1;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    hcnt_d      = 8'd0;
                    expired_d   = 1'b1;
                end else if (!hold_done) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                ptr_d       = 3'd0;
                hcnt_d      = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hcnt_q      <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hcnt_q      <= hcnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            expired_q   <= expired_d;
        end
    end

    grant_decoder u_decoder (
        .sel    (gnt_id_q),
        .en     (gnt_valid_q),
        .onehot (gnt)
    );

    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_grant_scheduler.sv
// Bench for grant_scheduler: two instances (MAX_HOLD=16 and MAX_HOLD=4) share stimulus.
// Expected outputs are queued as each stimulus cycle is driven and popped one edge later.
module tb_grant_scheduler;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       ex;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] req;

    logic [7:0] g16_gnt;
    logic       g16_vld;
    logic [2:0] g16_id;
    logic       g16_exp;
    logic [7:0] g4_gnt;
    logic       g4_vld;
    logic [2:0] g4_id;
    logic       g4_exp;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    grant_scheduler #(.MAX_HOLD(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .gnt       (g16_gnt),
        .gnt_valid (g16_vld),
        .gnt_id    (g16_id),
        .expired   (g16_exp)
    );

    grant_scheduler #(.MAX_HOLD(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .gnt       (g4_gnt),
        .gnt_valid (g4_vld),
        .gnt_id    (g4_id),
        .expired   (g4_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int id, input logic vld, input logic ex);
        exp_t e;
        e.gnt = vld ? (8'd1 << id) : 8'd0;
        e.id  = vld ? id[2:0] : 3'd0;
        e.vld = vld;
        e.ex  = ex;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [7:0] r, input logic en, input exp_t e);
        req    = r;
        enable = en;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        req    = 8'h00;
        tick();
        tick();
        checks++;
        if (g16_gnt !== 8'h00 || g16_vld !== 1'b0 || g16_id !== 3'd0 || g16_exp !== 1'b0) begin
            failures++;
            $display("FAIL reset16: gnt=%b vld=%b id=%0d exp=%b, want all zero", g16_gnt, g16_vld, g16_id, g16_exp);
        end
        enable = 1'b1;
        req    = 8'hFF;
        tick();
        checks++;
        if (g4_gnt !== 8'h00 || g4_vld !== 1'b0 || g4_id !== 3'd0 || g4_exp !== 1'b0) begin
            failures++;
            $display("FAIL reset_held4: gnt=%b vld=%b id=%0d exp=%b, want all zero", g4_gnt, g4_vld, g4_id, g4_exp);
        end
        req    = 8'h00;
        enable = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] r [8];
        exp_t       e [8];
        exp_t       want;
        r    = '{8'h05, 8'h05, 8'h04, 8'h04, 8'h01, 8'h05, 8'h00, 8'h00};
        e[0] = mk(0, 1, 0);
        e[1] = mk(0, 1, 0);
        e[2] = mk(0, 0, 0);
        e[3] = mk(2, 1, 0);
        e[4] = mk(0, 0, 0);
        e[5] = mk(0, 1, 0);
        e[6] = mk(0, 0, 0);
        e[7] = mk(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive_push(r[i], 1'b1, e[i]);
            tick();
            want = sb.pop_front();
            checks++;
            if (g16_gnt !== want.gnt || g16_id !== want.id || g16_vld !== want.vld || g16_exp !== want.ex) begin
                failures++;
                $display("FAIL basic[%0d]: got gnt=%b id=%0d vld=%b exp=%b, want gnt=%b id=%0d vld=%b exp=%b",
                         i, g16_gnt, g16_id, g16_vld, g16_exp, want.gnt, want.id, want.vld, want.ex);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t want;
        do_reset();
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 5; c++) begin
                if (c < 4)
                    drive_push(8'hFF, 1'b1, mk(g % 8, 1, 0));
                else if (g < 8)
                    drive_push(8'hFF, 1'b1, mk(0, 0, 1));
                else
                    drive_push(8'hFE, 1'b1, mk(0, 0, 0));
                tick();
                want = sb.pop_front();
                checks++;
                if (g4_gnt !== want.gnt || g4_id !== want.id || g4_vld !== want.vld || g4_exp !== want.ex) begin
                    failures++;
                    $display("FAIL rotation[g%0d c%0d]: got gnt=%b id=%0d vld=%b exp=%b, want gnt=%b id=%0d vld=%b exp=%b",
                             g, c, g4_gnt, g4_id, g4_vld, g4_exp, want.gnt, want.id, want.vld, want.ex);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0)
                drive_push(8'hFE, 1'b1, mk(1, 1, 0));
            else
                drive_push(8'h00, 1'b1, mk(0, 0, 0));
            tick();
            want = sb.pop_front();
            checks++;
            if (g4_gnt !== want.gnt || g4_id !== want.id || g4_vld !== want.vld || g4_exp !== want.ex) begin
                failures++;
                $display("FAIL rotation_tail[%0d]: got gnt=%b id=%0d vld=%b exp=%b, want gnt=%b id=%0d vld=%b exp=%b",
                         i, g4_gnt, g4_id, g4_vld, g4_exp, want.gnt, want.id, want.vld, want.ex);
            end
        end
    endtask

    task automatic test_hold();
        exp_t want;
        do_reset();
        for (int i = 0; i < 42; i++) begin
            if (i < 40)
                drive_push(8'h20, 1'b1, mk(5, 1, 0));
            else
                drive_push(8'h00, 1'b1, mk(0, 0, 0));
            tick();
            want = sb.pop_front();
            checks++;
            if (g16_gnt !== want.gnt || g16_id !== want.id || g16_vld !== want.vld || g16_exp !== want.ex) begin
                failures++;
                $display("FAIL hold16[%0d]: got gnt=%b id=%0d vld=%b exp=%b, want gnt=%b id=%0d vld=%b exp=%b",
                         i, g16_gnt, g16_id, g16_vld, g16_exp, want.gnt, want.id, want.vld, want.ex);
            end
            checks++;
            if (g4_gnt !== want.gnt || g4_exp !== want.ex) begin
                failures++;
                $display("FAIL hold4[%0d]: got gnt=%b exp=%b, want gnt=%b exp=%b",
                         i, g4_gnt, g4_exp, want.gnt, want.ex);
            end
        end
    endtask

    task automatic test_wrap_timeout();
        exp_t want;
        // ptr is 6 here (id 5 was last released).
        for (int i = 0; i < 20; i++) begin
            if (i == 0)
                drive_push(8'h80, 1'b1, mk(7, 1, 0));
            else if (i < 16)
                drive_push(8'h81, 1'b1, mk(7, 1, 0));
            else if (i == 16)
                drive_push(8'h81, 1'b1, mk(0, 0, 1));
            else if (i == 17)
                drive_push(8'h81, 1'b1, mk(0, 1, 0));
            else
                drive_push(8'h00, 1'b1, mk(0, 0, 0));
            tick();
            want = sb.pop_front();
            checks++;
            if (g16_gnt !== want.gnt || g16_id !== want.id || g16_vld !== want.vld || g16_exp !== want.ex) begin
                failures++;
                $display("FAIL wrap[%0d]: got gnt=%b id=%0d vld=%b exp=%b, want gnt=%b id=%0d vld=%b exp=%b",
                         i, g16_gnt, g16_id, g16_vld, g16_exp, want.gnt, want.id, want.vld, want.ex);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] r  [7];
        logic       en [7];
        exp_t       e  [7];
        exp_t       want;
        r    = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 8'h00, 8'h00};
        en   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e[0] = mk(3, 1, 0);
        e[1] = mk(0, 0, 0);
        e[2] = mk(0, 0, 0);
        e[3] = mk(0, 0, 0);
        e[4] = mk(4, 1, 0);
        e[5] = mk(0, 0, 0);
        e[6] = mk(0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            drive_push(r[i], en[i], e[i]);
            tick();
            want = sb.pop_front();
            checks++;
            if (g16_gnt !== want.gnt || g16_id !== want.id || g16_vld !== want.vld || g16_exp !== want.ex) begin
                failures++;
                $display("FAIL enable[%0d]: got gnt=%b id=%0d vld=%b exp=%b, want gnt=%b id=%0d vld=%b exp=%b",
                         i, g16_gnt, g16_id, g16_vld, g16_exp, want.gnt, want.id, want.vld, want.ex);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t want;
        // ptr is 5 here, so id 6 wins.
        drive_push(8'h40, 1'b1, mk(6, 1, 0));
        tick();
        want = sb.pop_front();
        checks++;
        if (g16_gnt !== want.gnt || g16_id !== want.id || g16_vld !== want.vld) begin
            failures++;
            $display("FAIL areset_pre: got gnt=%b id=%0d vld=%b, want gnt=%b id=%0d vld=%b",
                     g16_gnt, g16_id, g16_vld, want.gnt, want.id, want.vld);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (g16_gnt !== 8'h00 || g16_vld !== 1'b0 || g16_id !== 3'd0 || g16_exp !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate: gnt=%b vld=%b id=%0d exp=%b, want all zero", g16_gnt, g16_vld, g16_id, g16_exp);
        end
        tick();
        req = 8'h42;
        reset = 1'b0;
        checks++;
        if (g16_gnt !== 8'h00 || g16_exp !== 1'b0) begin
            failures++;
            $display("FAIL areset_after_edge: gnt=%b exp=%b, want 0 and 0", g16_gnt, g16_exp);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0)
                drive_push(8'h42, 1'b1, mk(1, 1, 0));
            else
                drive_push(8'h00, 1'b1, mk(0, 0, 0));
            tick();
            want = sb.pop_front();
            checks++;
            if (g16_gnt !== want.gnt || g16_id !== want.id || g16_vld !== want.vld || g16_exp !== want.ex) begin
                failures++;
                $display("FAIL areset_post[%0d]: got gnt=%b id=%0d vld=%b exp=%b, want gnt=%b id=%0d vld=%b exp=%b",
                         i, g16_gnt, g16_id, g16_vld, g16_exp, want.gnt, want.id, want.vld, want.ex);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        req    = 8'h00;
        test_reset();
        test_basic();
        test_rotation();
        test_hold();
        test_wrap_timeout();
        test_enable_drop();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grant_scheduler.md
GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum cycles one requester may hold the grant while others wait (range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  arbitration enable; low blocks new grants and revokes any current grant.
REQ-005 Port: req  input  8  request vector, req[i] high = requester i wants the shared resource.
REQ-006 Port: gnt  output  8  one-hot grant vector, all-zero when nothing is granted.
REQ-007 Port: gnt_valid  output  1  high when exactly one gnt bit is high.
REQ-008 Port: gnt_id  output  3  binary index of the granted requester; 0 when gnt_valid is low.
REQ-009 Port: expired  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD timeout.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT and RELEASE.
REQ-011 Round-robin pointer ptr (3 bits) SHALL select the winner: the first i with req[i]=1, searching ptr, ptr+1, ... mod 8.
REQ-012 In IDLE or RELEASE with enable=1 and req nonzero, the next edge SHALL register the winner into gnt_id, set gnt_valid and enter GRANT.
REQ-013 In IDLE or RELEASE with enable=0 or req=0, the next edge SHALL enter IDLE with all grant outputs low.
REQ-014 Grant latency SHALL be one clock: req sampled at edge k in IDLE gives gnt high immediately after edge k.
REQ-015 gnt SHALL be the 3-to-8 decode of gnt_id, gated by gnt_valid: gnt[gnt_id]=1 and all other bits 0.
REQ-016 In GRANT, hold counter hcnt (8 bits) SHALL clear on entry and increment each cycle, saturating at MAX_HOLD-1.
REQ-017 In GRANT, req[gnt_id]=0 SHALL cause a transition to RELEASE at the next edge.
REQ-018 In GRANT, enable=0 SHALL cause a transition to RELEASE at the next edge.
REQ-019 In GRANT, hcnt=MAX_HOLD-1 with any other req bit high SHALL cause RELEASE at the next edge, and expired SHALL pulse for that one cycle.
REQ-020 In GRANT with hcnt saturated and no other requester pending, the grant SHALL be held indefinitely, with no expired pulse.
REQ-021 On every GRANT->RELEASE transition, ptr SHALL become gnt_id+1 mod 8 (wrap 7->0).
REQ-022 RELEASE SHALL last exactly one cycle with gnt=0, gnt_valid=0 and gnt_id=0; this dead cycle is the mandatory hand-over gap.
REQ-023 When RELEASE exit (REQ-017) and timeout (REQ-019) coincide, release SHALL take priority and expired SHALL NOT pulse.
REQ-024 A requester that drops req and re-raises it during RELEASE SHALL be arbitrated normally from the updated ptr.
REQ-025 Two grant bits SHALL never be high in the same cycle.

Reset
REQ-026 Asserting reset SHALL immediately force: state=IDLE, ptr=0, hcnt=0, gnt=0, gnt_valid=0, gnt_id=0, expired=0.
REQ-027 Reset asserted mid-GRANT SHALL drop the grant asynchronously, with no RELEASE cycle and no expired pulse.
REQ-028 After reset deasserts, the first arbitration SHALL start from ptr=0.

Structure
REQ-029 FSM state encoding and the default MAX_HOLD SHALL live in a shared package, grant_pkg.
REQ-030 The one-hot generation SHALL be a sub-module, grant_decoder (3-bit select plus enable in, 8-bit one-hot out), instantiated once.
REQ-031 Winner search SHALL be combinational; all outputs SHALL be registered or derived only from registered state.

Verification
REQ-032 Reset, then req=8'b0000_0101 held -> gnt=8'b0000_0001 one cycle later; drop req[0] -> one RELEASE cycle, then gnt=8'b0000_0100, gnt_id=2.
REQ-033 req=8'hFF held, MAX_HOLD=4 -> grants rotate 0,1,...,7,0; each grant lasts 4 cycles followed by 1 dead cycle; expired pulses at the end of each grant.
REQ-034 Only req[5] high for 40 cycles, MAX_HOLD=16 -> gnt[5] held all 40 cycles, expired never pulses.
REQ-035 Grant on id 7, then req=8'b1000_0001 -> after release, next grant id 0 (ptr wrap).
REQ-036 Mid-GRANT on id 3, enable drops -> RELEASE next edge, then IDLE; enable re-raised -> id 3 is not regranted ahead of higher ids still pending (ptr=4).
REQ-037 Mid-GRANT on id 6, assert reset asynchronously -> gnt=0 before the next clk edge; after release, req=8'b0100_0010 -> gnt_id=1.
